// File: rtl/pic_row_writer_if.sv
// Pixel stream handshake between a pixel source and pic_row_writer.
//   px_valid  source -> writer  pixel present on px_data/px_sof
//   px_data   source -> writer  pixel value, 1=white, 0=black
//   px_sof    source -> writer  pixel is row 0, column 0 of a frame
//   px_ready  writer -> source  writer accepts a pixel this cycle
// A pixel transfers on a rising clk edge where px_valid & px_ready.
interface pic_row_writer_if;
  logic px_valid;
  logic px_data;
  logic px_sof;
  logic px_ready;

  modport master (output px_valid, output px_data, output px_sof, input px_ready);
  modport slave  (input px_valid, input px_data, input px_sof, output px_ready);
endinterface

// File: rtl/pic_row_writer.sv
// Write side of the picture store. A serial 1-bit pixel stream is packed into
// WIDTH-bit row words (first pixel of a row in bit WIDTH-1, last in bit 0) and
// committed into a ROWS x WIDTH memory. After reset the memory is cleared to
// all ones (white), one row per cycle.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   px (slave)           pixel stream handshake
//   frame_done           one-cycle pulse while the last row of a frame commits
//   busy                 high in CLEAR, FILL and COMMIT
//   rd_addr, rd_offset   display row address and vertical scroll offset
//   rd_q                 combinational row data for (rd_addr - rd_offset),
//                        all ones when that index is beyond the last row
module pic_row_writer #(
  parameter int WIDTH = 240,
  parameter int ROWS  = 320,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             rst,
  pic_row_writer_if.slave  px,
  output logic             frame_done,
  output logic             busy,
  input  logic [AW-1:0]    rd_addr,
  input  logic [AW-1:0]    rd_offset,
  output logic [WIDTH-1:0] rd_q
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);

  typedef enum logic [1:0] {CLEAR, IDLE, FILL, COMMIT} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    clr_row_q, clr_row_d;
  logic [AW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             px_ready_q, px_ready_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] mem [ROWS];

  logic             xfer;
  logic [WIDTH-1:0] sh_in;
  logic [AW-1:0]    rd_idx;

  assign xfer  = px.px_valid & px_ready_q;
  assign sh_in = {sh_q[WIDTH-2:0], px.px_data};

  always_comb begin
    state_d   = state_q;
    clr_row_d = clr_row_q;
    row_d     = row_q;
    col_d     = col_q;
    sh_d      = sh_q;
    case (state_q)
      CLEAR: begin
        if (clr_row_q == LAST_ROW) state_d = IDLE;
        else                       clr_row_d = clr_row_q + 1'b1;
      end
      IDLE: begin
        // Pixels without start-of-frame are consumed and dropped here.
        if (xfer && px.px_sof) begin
          sh_d    = sh_in;
          row_d   = '0;
          col_d   = CW'(1);
          state_d = FILL;
        end
      end
      FILL: begin
        if (xfer) begin
          sh_d = sh_in;
          if (px.px_sof) begin
            // Restart: this pixel becomes pixel 0 of row 0; committed rows stay.
            row_d = '0;
            col_d = CW'(1);
          end else if (col_q == LAST_COL) begin
            state_d = COMMIT;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      COMMIT: begin
        if (row_q == LAST_ROW) begin
          state_d = IDLE;
        end else begin
          row_d   = row_q + 1'b1;
          col_d   = '0;
          state_d = FILL;
        end
      end
      default: state_d = CLEAR;
    endcase

    // Outputs are registered, so they are derived from the next state.
    px_ready_d   = (state_d == IDLE) || (state_d == FILL);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == COMMIT) && (row_d == LAST_ROW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR;
      clr_row_q    <= '0;
      row_q        <= '0;
      col_q        <= '0;
      sh_q         <= '1;
      px_ready_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      clr_row_q    <= clr_row_d;
      row_q        <= row_d;
      col_q        <= col_d;
      sh_q         <= sh_d;
      px_ready_q   <= px_ready_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  // Storage array is not reset; CLEAR initialises it after every reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR)       mem[clr_row_q] <= '1;
      else if (state_q == COMMIT) mem[row_q]     <= sh_q;
    end
  end

  // Scroll index wraps at AW bits; indices past the last row read as white.
  assign rd_idx = rd_addr - rd_offset;
  assign rd_q   = (rd_idx <= LAST_ROW) ? mem[rd_idx] : '1;

  assign px.px_ready = px_ready_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pic_row_writer.sv
module tb_pic_row_writer;
  // Reduced row width keeps full-frame tests within a small cycle budget;
  // the frame height keeps its real value.
  localparam int W  = 24;
  localparam int R  = 320;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pic_row_writer_if bus ();
  logic          frame_done;
  logic          busy;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] rd_offset;
  logic [W-1:0]  rd_q;

  pic_row_writer #(.WIDTH(W), .ROWS(R), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .px         (bus),
    .frame_done (frame_done),
    .busy       (busy),
    .rd_addr    (rd_addr),
    .rd_offset  (rd_offset),
    .rd_q       (rd_q)
  );

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int rdy_low = 0;

  // Reference picture: what each row should hold, updated per whole row sent.
  logic [W-1:0] model_mem [R];

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (bus.px_ready === 1'b0) rdy_low++;
  end

  function automatic logic [W-1:0] exp_rd(int a, int o);
    int idx;
    idx = (a - o) & ((1 << AW) - 1);
    if (idx < R) return model_mem[idx];
    return '1;
  endfunction

  // kind 0: even rows black, odd rows 1,0,1,0...; kind 1: all black; kind 2: random
  function automatic logic [W-1:0] gen_row(int kind, int r);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (kind == 0)      w[W-1-i] = (r % 2 == 1) && (i % 2 == 0);
      else if (kind == 2) w[W-1-i] = 1'($urandom_range(0, 1));
    end
    return w;
  endfunction

  task automatic abort_run(string what);
    checks++;
    errors++;
    $display("FAIL %s timed out", what);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "stopped");
  endtask

  task automatic send_px(input logic d, input logic s, input bit rnd);
    int guard;
    guard = 0;
    if (rnd) begin
      while ($urandom_range(0, 1) == 1) begin
        bus.px_valid = 1'b0;
        bus.px_data  = 1'($urandom);
        bus.px_sof   = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    bus.px_valid = 1'b1;
    bus.px_data  = d;
    bus.px_sof   = s;
    while (bus.px_ready !== 1'b1) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 1000) abort_run("px_ready wait");
    end
    @(posedge clk); #1;
    bus.px_valid = 1'b0;
    bus.px_sof   = 1'b0;
  endtask

  task automatic send_row(input logic [W-1:0] w, input bit sof_first, input int npix, input bit rnd);
    for (int i = 0; i < npix; i++) send_px(w[W-1-i], sof_first && (i == 0), rnd);
  endtask

  task automatic send_frame(input int kind, input bit rnd, output int fd_early, output int fd_total);
    int fd0;
    int n;
    logic [W-1:0] w;
    fd0 = fd_cnt;
    fd_early = 0;
    for (int r = 0; r < R; r++) begin
      w = gen_row(kind, r);
      for (int i = 0; i < W; i++) begin
        if (r == R - 1 && i == W - 1) fd_early = fd_cnt - fd0;
        send_px(w[W-1-i], (r == 0) && (i == 0), rnd);
      end
      model_mem[r] = w;
    end
    n = 0;
    while (fd_cnt == fd0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    fd_total = fd_cnt - fd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.px_valid = 1'b1;
    bus.px_data  = 1'b1;
    bus.px_sof   = 1'b0;
    rd_addr = '0;
    rd_offset = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.px_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.px_ready); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
  endtask

  task automatic test_clear();
    int n;
    int busy_bad;
    int addrs [3];
    addrs = '{0, 319, 400};
    rst = 1'b0;
    n = 0;
    busy_bad = 0;
    while (bus.px_ready !== 1'b1 && n < 2000) begin
      if (busy !== 1'b1) busy_bad++;
      n++;
      @(posedge clk); #1;
    end
    bus.px_valid = 1'b0;
    checks++;
    if (n != R) begin errors++; $display("FAIL clear_ready_low_cycles got %0d want %0d", n, R); end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL clear_busy_low_cycles got %0d want 0", busy_bad); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    for (int r = 0; r < R; r++) model_mem[r] = '1;
    foreach (addrs[k]) begin
      rd_addr = AW'(addrs[k]);
      rd_offset = '0;
      #1;
      checks++;
      if (rd_q !== exp_rd(addrs[k], 0)) begin
        errors++;
        $display("FAIL clear_read addr %0d got %h want %h", addrs[k], rd_q, exp_rd(addrs[k], 0));
      end
    end
  endtask

  task automatic test_frame();
    int fd_early, fd_total, rl0;
    logic [W-1:0] alt;
    for (int i = 0; i < 5; i++) send_px(1'($urandom), 1'b0, 1'b0);
    rl0 = rdy_low;
    send_frame(0, 1'b0, fd_early, fd_total);
    checks++;
    if (fd_early != 0) begin errors++; $display("FAIL frame_done_early got %0d want 0", fd_early); end
    checks++;
    if (fd_total != 1) begin errors++; $display("FAIL frame_done_count got %0d want 1", fd_total); end
    checks++;
    if (rdy_low - rl0 != R) begin errors++; $display("FAIL frame_ready_low got %0d want %0d", rdy_low - rl0, R); end
    alt = '0;
    for (int i = 0; i < W; i += 2) alt[W-1-i] = 1'b1;
    rd_offset = '0;
    rd_addr = AW'(1);
    #1;
    checks++;
    if (rd_q !== alt) begin errors++; $display("FAIL frame_row1 got %h want %h", rd_q, alt); end
    for (int r = 0; r < R; r++) begin
      rd_addr = AW'(r);
      #1;
      checks++;
      if (rd_q !== exp_rd(r, 0)) begin
        errors++;
        $display("FAIL frame_row %0d got %h want %h", r, rd_q, exp_rd(r, 0));
      end
    end
  endtask

  task automatic test_scroll();
    int a, o;
    for (int k = 0; k < 23; k++) begin
      case (k)
        0: begin a = 7; o = 5; end
        1: begin a = 2; o = 5; end
        2: begin a = 6; o = 5; end
        default: begin a = $urandom_range(0, 511); o = $urandom_range(0, 511); end
      endcase
      rd_addr = AW'(a);
      rd_offset = AW'(o);
      #1;
      checks++;
      if (rd_q !== exp_rd(a, o)) begin
        errors++;
        $display("FAIL scroll addr %0d off %0d got %h want %h", a, o, rd_q, exp_rd(a, o));
      end
    end
    rd_offset = '0;
  endtask

  task automatic test_abort();
    int fd0, fd_early, fd_total;
    logic [W-1:0] w;
    fd0 = fd_cnt;
    for (int r = 0; r < 3; r++) begin
      w = gen_row(2, r);
      send_row(w, r == 0, W, 1'b0);
      model_mem[r] = w;
    end
    send_row(gen_row(2, 3), 1'b0, 10, 1'b0);
    send_frame(1, 1'b0, fd_early, fd_total);
    checks++;
    if (fd_early != 0) begin errors++; $display("FAIL abort_frame_done_early got %0d want 0", fd_early); end
    checks++;
    if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL abort_frame_done_count got %0d want 1", fd_cnt - fd0); end
    for (int r = 0; r < R; r++) begin
      rd_addr = AW'(r);
      #1;
      checks++;
      if (rd_q !== exp_rd(r, 0)) begin
        errors++;
        $display("FAIL abort_row %0d got %h want %h", r, rd_q, exp_rd(r, 0));
      end
    end
  endtask

  task automatic test_random_valid();
    int fd_early, fd_total, rl0;
    rl0 = rdy_low;
    send_frame(0, 1'b1, fd_early, fd_total);
    checks++;
    if (fd_early != 0) begin errors++; $display("FAIL rnd_frame_done_early got %0d want 0", fd_early); end
    checks++;
    if (fd_total != 1) begin errors++; $display("FAIL rnd_frame_done_count got %0d want 1", fd_total); end
    checks++;
    if (rdy_low - rl0 != R) begin errors++; $display("FAIL rnd_ready_low got %0d want %0d", rdy_low - rl0, R); end
    for (int r = 0; r < R; r++) begin
      rd_addr = AW'(r);
      #1;
      checks++;
      if (rd_q !== exp_rd(r, 0)) begin
        errors++;
        $display("FAIL rnd_row %0d got %h want %h", r, rd_q, exp_rd(r, 0));
      end
    end
  endtask

  task automatic test_reset_mid_row();
    int fd0, n, busy_bad;
    logic [W-1:0] w;
    for (int r = 0; r < 10; r++) begin
      w = gen_row(2, r);
      send_row(w, r == 0, W, 1'b0);
      model_mem[r] = w;
    end
    send_row(gen_row(2, 10), 1'b0, 5, 1'b0);
    fd0 = fd_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    busy_bad = 0;
    while (bus.px_ready !== 1'b1 && n < 2000) begin
      if (busy !== 1'b1) busy_bad++;
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n != R) begin errors++; $display("FAIL rst_mid_ready_low_cycles got %0d want %0d", n, R); end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL rst_mid_busy_low_cycles got %0d want 0", busy_bad); end
    for (int r = 0; r < R; r++) model_mem[r] = '1;
    for (int r = 0; r < R; r++) begin
      rd_addr = AW'(r);
      #1;
      checks++;
      if (rd_q !== exp_rd(r, 0)) begin
        errors++;
        $display("FAIL rst_mid_row %0d got %h want %h", r, rd_q, exp_rd(r, 0));
      end
    end
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if (fd_cnt - fd0 != 0) begin errors++; $display("FAIL rst_mid_frame_done got %0d want 0", fd_cnt - fd0); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_frame();
    test_scroll();
    test_abort();
    test_random_valid();
    test_reset_mid_row();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
